// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered decode stage between fetch and execute.
// Decodes opcode/func into the control bundle, holds it in an output
// register behind a valid/ready handshake, inserts a single bubble on a
// load-use hazard and blocks issue while a DIVU occupies the divider.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on current state and inputs and never on
// in_valid. Once out_valid is high the bundle is held unchanged until
// out_ready is seen high, unless rst or flush squashes it.
//
// Local encodings:
//   out_cb       0 nojump, 1 br_beq, 2 br_j
//   out_mwa_sel  0 rt, 1 rd
//   out_mwd_sel  0 alu result, 1 memory data
//   out_alu1_sel 0 rs, 1 shamt
//   out_alu2_sel 0 rt, 1 sign-extended imm, 2 zero-extended imm
//   out_alu_sel  0 direct1, 1 add, 2 sub, 3 or, 4 sll, 5 srl, 6 lui, 7 divu
module ctrl_pipe #(
    parameter int ALU_SEL_WIDTH = 4,
    parameter int DIV_LAT       = 32,
    parameter bit LOAD_USE_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_opcode,
    input  logic [5:0]               in_func,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_cb,
    output logic                     out_dmem_we,
    output logic                     out_reg_we,
    output logic                     out_mwa_sel,
    output logic                     out_mwd_sel,
    output logic [ALU_SEL_WIDTH-1:0] out_alu_sel,
    output logic [1:0]               out_alu1_sel,
    output logic [1:0]               out_alu2_sel,
    output logic [4:0]               out_wa,
    output logic                     out_illegal,
    output logic                     busy
);

    localparam int CNT_W = ($clog2(DIV_LAT) > 1) ? $clog2(DIV_LAT) : 1;
    // DIV_WAIT covers DIV_LAT-1 cycles; the counter runs reload..0.
    localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    localparam logic [3:0] CB_NOJUMP = 4'd0;
    localparam logic [3:0] CB_BEQ    = 4'd1;
    localparam logic [3:0] CB_J      = 4'd2;

    localparam logic [ALU_SEL_WIDTH-1:0] ALU_DIRECT1 = ALU_SEL_WIDTH'(0);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_ADD     = ALU_SEL_WIDTH'(1);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SUB     = ALU_SEL_WIDTH'(2);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OR      = ALU_SEL_WIDTH'(3);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLL     = ALU_SEL_WIDTH'(4);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SRL     = ALU_SEL_WIDTH'(5);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_LUI     = ALU_SEL_WIDTH'(6);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_DIVU    = ALU_SEL_WIDTH'(7);

    typedef struct packed {
        logic [3:0]               cb;
        logic                     dmem_we;
        logic                     reg_we;
        logic                     mwa_sel;
        logic                     mwd_sel;
        logic [ALU_SEL_WIDTH-1:0] alu_sel;
        logic [1:0]               alu1_sel;
        logic [1:0]               alu2_sel;
        logic [4:0]               wa;
        logic                     illegal;
    } bundle_t;

    typedef enum logic {RUN = 1'b0, DIV_WAIT = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    bundle_t          dec;
    bundle_t          held;
    logic             held_lw;
    logic             dec_lw;
    logic             dec_divu;
    logic             reads_rs;
    logic             reads_rt;
    logic             hazard;
    logic             accept;

    // Decode the incoming instruction into a candidate bundle and hazard info.
    always_comb begin
        dec      = '0;
        dec.cb   = CB_NOJUMP;
        dec_lw   = 1'b0;
        dec_divu = 1'b0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        if (in_opcode == OP_RTYPE) begin
            case (in_func)
                FN_ADD, FN_ADDU: begin
                    dec.reg_we = 1'b1; dec.mwa_sel = 1'b1; dec.alu_sel = ALU_ADD;
                    reads_rs = 1'b1; reads_rt = 1'b1;
                end
                FN_SUB: begin
                    dec.reg_we = 1'b1; dec.mwa_sel = 1'b1; dec.alu_sel = ALU_SUB;
                    reads_rs = 1'b1; reads_rt = 1'b1;
                end
                FN_DIVU: begin
                    // Quotient lands in the divider's own registers, not the file.
                    dec.alu_sel = ALU_DIVU; dec_divu = 1'b1;
                    reads_rs = 1'b1; reads_rt = 1'b1;
                end
                FN_SLL: begin
                    dec.reg_we = 1'b1; dec.mwa_sel = 1'b1; dec.alu_sel = ALU_SLL;
                    dec.alu1_sel = 2'd1; reads_rt = 1'b1;
                end
                FN_SRL: begin
                    dec.reg_we = 1'b1; dec.mwa_sel = 1'b1; dec.alu_sel = ALU_SRL;
                    dec.alu1_sel = 2'd1; reads_rt = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            case (in_opcode)
                OP_LUI: begin
                    dec.reg_we = 1'b1; dec.alu_sel = ALU_LUI; dec.alu2_sel = 2'd2;
                end
                OP_ADDIU: begin
                    dec.reg_we = 1'b1; dec.alu_sel = ALU_ADD; dec.alu2_sel = 2'd1;
                    reads_rs = 1'b1;
                end
                OP_LW: begin
                    dec.reg_we = 1'b1; dec.mwd_sel = 1'b1; dec.alu_sel = ALU_ADD;
                    dec.alu2_sel = 2'd1; dec_lw = 1'b1; reads_rs = 1'b1;
                end
                OP_SW: begin
                    dec.dmem_we = 1'b1; dec.alu_sel = ALU_ADD; dec.alu2_sel = 2'd1;
                    reads_rs = 1'b1; reads_rt = 1'b1;
                end
                OP_BEQ: begin
                    dec.cb = CB_BEQ; dec.alu_sel = ALU_SUB;
                    reads_rs = 1'b1; reads_rt = 1'b1;
                end
                OP_J: begin
                    dec.cb = CB_J; dec.alu_sel = ALU_DIRECT1;
                end
                OP_ORI: begin
                    dec.reg_we = 1'b1; dec.alu_sel = ALU_OR; dec.alu2_sel = 2'd2;
                    reads_rs = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        if (dec.reg_we) begin
            dec.wa = dec.mwa_sel ? in_rd : in_rt;
        end
    end

    // A held load whose target is read by the incoming instruction blocks issue.
    assign hazard = LOAD_USE_EN && out_valid && held_lw && (held.wa != 5'd0) &&
                    ((reads_rs && (in_rs == held.wa)) || (reads_rt && (in_rt == held.wa)));

    assign in_ready = !rst && !flush && (state == RUN) && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == DIV_WAIT);

    // Divider FSM and output register; bubbles clear the whole bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            held      <= '0;
            held_lw   <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= RUN;
            cnt       <= '0;
            held      <= '0;
            held_lw   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state == DIV_WAIT) begin
                if (cnt == '0) begin
                    state <= RUN;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (accept && dec_divu && (DIV_LAT > 1)) begin
                state <= DIV_WAIT;
                cnt   <= DIV_RELOAD;
            end

            if (accept) begin
                held      <= dec;
                held_lw   <= dec_lw;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                held      <= '0;
                held_lw   <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end

    assign out_cb       = held.cb;
    assign out_dmem_we  = held.dmem_we;
    assign out_reg_we   = held.reg_we;
    assign out_mwa_sel  = held.mwa_sel;
    assign out_mwd_sel  = held.mwd_sel;
    assign out_alu_sel  = held.alu_sel;
    assign out_alu1_sel = held.alu1_sel;
    assign out_alu2_sel = held.alu2_sel;
    assign out_wa       = held.wa;
    assign out_illegal  = held.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios followed by random traffic for ctrl_pipe.
// A behavioural model tracks what execute should see; a monitor compares
// the DUT against it on every falling edge.
module tb_ctrl_pipe;

    localparam int W       = 22;
    localparam int DIV_LAT = 4;

    typedef enum int {
        I_ADD, I_ADDU, I_SUB, I_DIVU, I_SLL, I_SRL, I_LUI,
        I_ADDIU, I_LW, I_SW, I_BEQ, I_J, I_ORI, I_BAD
    } instr_e;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [5:0] in_opcode, in_func;
    logic [4:0] in_rs, in_rt, in_rd;
    logic [3:0] out_cb;
    logic       out_dmem_we, out_reg_we, out_mwa_sel, out_mwd_sel, out_illegal, busy;
    logic [3:0] out_alu_sel;
    logic [1:0] out_alu1_sel, out_alu2_sel;
    logic [4:0] out_wa;

    logic       n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready;
    logic [5:0] n_opcode, n_func;
    logic [4:0] n_rs, n_rt, n_rd;
    logic [3:0] n_cb;
    logic       n_dmem_we, n_reg_we, n_mwa_sel, n_mwd_sel, n_illegal, n_busy;
    logic [3:0] n_alu_sel;
    logic [1:0] n_alu1_sel, n_alu2_sel;
    logic [4:0] n_wa;

    ctrl_pipe #(.ALU_SEL_WIDTH(4), .DIV_LAT(DIV_LAT), .LOAD_USE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_cb(out_cb),
        .out_dmem_we(out_dmem_we), .out_reg_we(out_reg_we), .out_mwa_sel(out_mwa_sel),
        .out_mwd_sel(out_mwd_sel), .out_alu_sel(out_alu_sel), .out_alu1_sel(out_alu1_sel),
        .out_alu2_sel(out_alu2_sel), .out_wa(out_wa), .out_illegal(out_illegal), .busy(busy)
    );

    ctrl_pipe #(.ALU_SEL_WIDTH(4), .DIV_LAT(DIV_LAT), .LOAD_USE_EN(1'b0)) dut_nl (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_opcode(n_opcode), .in_func(n_func), .in_rs(n_rs), .in_rt(n_rt), .in_rd(n_rd),
        .flush(n_flush), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_cb(n_cb),
        .out_dmem_we(n_dmem_we), .out_reg_we(n_reg_we), .out_mwa_sel(n_mwa_sel),
        .out_mwd_sel(n_mwd_sel), .out_alu_sel(n_alu_sel), .out_alu1_sel(n_alu1_sel),
        .out_alu2_sel(n_alu2_sel), .out_wa(n_wa), .out_illegal(n_illegal), .busy(n_busy)
    );

    logic [W-1:0] act_vec;
    assign act_vec = {out_cb, out_dmem_we, out_reg_we, out_mwa_sel, out_mwd_sel, out_alu_sel,
                      out_alu1_sel, out_alu2_sel, out_wa, out_illegal};

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: instruction classes and their control table
    function automatic instr_e classify(input logic [5:0] op, input logic [5:0] fn);
        instr_e r;
        r = I_BAD;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: r = I_ADD;
                    6'b100001: r = I_ADDU;
                    6'b100010: r = I_SUB;
                    6'b011011: r = I_DIVU;
                    6'b000000: r = I_SLL;
                    6'b000010: r = I_SRL;
                    default:   r = I_BAD;
                endcase
            end
            6'b001111: r = I_LUI;
            6'b001001: r = I_ADDIU;
            6'b100011: r = I_LW;
            6'b101011: r = I_SW;
            6'b000100: r = I_BEQ;
            6'b000010: r = I_J;
            6'b001101: r = I_ORI;
            default:   r = I_BAD;
        endcase
        return r;
    endfunction

    function automatic logic [11:0] enc(input instr_e k);
        logic [11:0] r;
        case (k)
            I_ADD:   r = {6'b000000, 6'b100000};
            I_ADDU:  r = {6'b000000, 6'b100001};
            I_SUB:   r = {6'b000000, 6'b100010};
            I_DIVU:  r = {6'b000000, 6'b011011};
            I_SLL:   r = {6'b000000, 6'b000000};
            I_SRL:   r = {6'b000000, 6'b000010};
            I_LUI:   r = {6'b001111, 6'b000000};
            I_ADDIU: r = {6'b001001, 6'b000000};
            I_LW:    r = {6'b100011, 6'b000000};
            I_SW:    r = {6'b101011, 6'b000000};
            I_BEQ:   r = {6'b000100, 6'b000000};
            I_J:     r = {6'b000010, 6'b000000};
            I_ORI:   r = {6'b001101, 6'b000000};
            default: r = {6'b111111, 6'b000000};
        endcase
        return r;
    endfunction

    function automatic logic [11:0] enc_reserved(input int sel);
        logic [11:0] r;
        case (sel)
            0:       r = {6'b111111, 6'b000000};
            1:       r = {6'b000001, 6'b100000};
            2:       r = {6'b010000, 6'b000010};
            3:       r = {6'b000000, 6'b111111};
            default: r = {6'b000000, 6'b001000};
        endcase
        return r;
    endfunction

    function automatic bit reads_rs(input instr_e k);
        return k inside {I_ADDIU, I_ADD, I_ADDU, I_SUB, I_DIVU, I_LW, I_SW, I_BEQ, I_ORI};
    endfunction

    function automatic bit reads_rt(input instr_e k);
        return k inside {I_ADD, I_ADDU, I_SUB, I_DIVU, I_SLL, I_SRL, I_SW, I_BEQ};
    endfunction

    // Packed as {cb, dmem_we, reg_we, mwa_sel, mwd_sel, alu_sel, alu1, alu2, wa, illegal}.
    function automatic logic [W-1:0] expect_bundle(input instr_e k, input logic [4:0] rt,
                                                   input logic [4:0] rd);
        logic [3:0] cb, alu;
        logic       dm, rw, mwa, mwd, ill;
        logic [1:0] a1, a2;
        logic [4:0] wa;
        cb = 4'd0; alu = 4'd0; dm = 1'b0; rw = 1'b0; mwa = 1'b0; mwd = 1'b0;
        ill = 1'b0; a1 = 2'd0; a2 = 2'd0;
        case (k)
            I_ADD, I_ADDU: begin rw = 1'b1; mwa = 1'b1; alu = 4'd1; end
            I_SUB:   begin rw = 1'b1; mwa = 1'b1; alu = 4'd2; end
            I_DIVU:  alu = 4'd7;
            I_SLL:   begin rw = 1'b1; mwa = 1'b1; alu = 4'd4; a1 = 2'd1; end
            I_SRL:   begin rw = 1'b1; mwa = 1'b1; alu = 4'd5; a1 = 2'd1; end
            I_LUI:   begin rw = 1'b1; alu = 4'd6; a2 = 2'd2; end
            I_ADDIU: begin rw = 1'b1; alu = 4'd1; a2 = 2'd1; end
            I_LW:    begin rw = 1'b1; mwd = 1'b1; alu = 4'd1; a2 = 2'd1; end
            I_SW:    begin dm = 1'b1; alu = 4'd1; a2 = 2'd1; end
            I_BEQ:   begin cb = 4'd1; alu = 4'd2; end
            I_J:     cb = 4'd2;
            I_ORI:   begin rw = 1'b1; alu = 4'd3; a2 = 2'd2; end
            default: ill = 1'b1;
        endcase
        wa = !rw ? 5'd0 : (mwa ? rd : rt);
        return {cb, dm, rw, mwa, mwd, alu, a1, a2, wa, ill};
    endfunction

    // model state: what sits in front of execute and how long the divider is busy
    bit         started = 1'b0;
    bit         m_valid = 1'b0;
    instr_e     m_kind  = I_BAD;
    logic [4:0] m_wa    = 5'd0;
    int         m_div_left = 0;

    function automatic bit model_hazard();
        instr_e k;
        k = classify(in_opcode, in_func);
        return m_valid && (m_kind == I_LW) && (m_wa != 5'd0) &&
               ((reads_rs(k) && (in_rs == m_wa)) || (reads_rt(k) && (in_rt == m_wa)));
    endfunction

    function automatic bit model_ready();
        return !rst && !flush && (m_div_left == 0) && !model_hazard() && (!m_valid || out_ready);
    endfunction

    // model update on each rising edge; accepted instructions go on the queue
    always @(posedge clk) begin
        bit           acc;
        instr_e       k;
        logic [W-1:0] e;
        started = 1'b1;
        k = classify(in_opcode, in_func);
        if (rst) begin
            m_valid = 1'b0;
            m_div_left = 0;
            exp_q.delete();
        end else if (flush) begin
            m_valid = 1'b0;
            m_div_left = 0;
        end else begin
            acc = in_valid && model_ready();
            if (m_div_left > 0) m_div_left--;
            if (acc) begin
                e = expect_bundle(k, in_rt, in_rd);
                exp_q.push_back(e);
                m_valid = 1'b1;
                m_kind  = k;
                m_wa    = e[5:1];
                if (k == I_DIVU && DIV_LAT > 1) m_div_left = DIV_LAT - 1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // monitor: compares DUT against the model mid-cycle
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                check("reset_bundle", 32'(act_vec), 32'd0);
                check("reset_out_valid", 32'(out_valid), 32'd0);
                check("reset_in_ready", 32'(in_ready), 32'd0);
                check("reset_busy", 32'(busy), 32'd0);
            end else begin
                check("in_ready", 32'(in_ready), 32'(model_ready()));
                check("busy", 32'(busy), 32'(m_div_left > 0));
                check("out_valid", 32'(out_valid), 32'(m_valid));
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL bundle: got 0x%0h expected nothing queued", act_vec);
                    end else begin
                        check("bundle", 32'(act_vec), 32'(exp_q[0]));
                        if (out_ready || flush) void'(exp_q.pop_front());
                    end
                end else begin
                    check("bubble_fields", 32'({out_reg_we, out_dmem_we, out_cb}), 32'd0);
                end
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input instr_e k, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
        in_valid = v;
        {in_opcode, in_func} = enc(k);
        in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    task automatic set_nl(input bit v, input instr_e k, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
        n_in_valid = v;
        {n_opcode, n_func} = enc(k);
        n_rs = rs; n_rt = rt; n_rd = rd;
    endtask

    initial begin
        instr_e k;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_in(1'b1, I_ADDU, 5'd1, 5'd2, 5'd3);
        n_flush = 1'b0; n_out_ready = 1'b1;
        set_nl(1'b0, I_SLL, 5'd0, 5'd0, 5'd0);

        // reset held three cycles with a pending instruction
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_ready_after_reset", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;

        // addu rs=1 rt=2 rd=3
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_reg_we", 32'(out_reg_we), 32'd1);
        check("t2_wa", 32'(out_wa), 32'd3);
        check("t2_mwa_sel", 32'(out_mwa_sel), 32'd1);
        check("t2_alu_sel", 32'(out_alu_sel), 32'd1);
        check("t2_illegal", 32'(out_illegal), 32'd0);

        // lw rt=5 held against a stalled execute
        cyc();
        out_ready = 1'b0;
        set_in(1'b1, I_LW, 5'd0, 5'd5, 5'd0);
        @(negedge clk);
        check("t3_ready_empty", 32'(in_ready), 32'd1);
        cyc();
        set_in(1'b1, I_ORI, 5'd1, 5'd6, 5'd0);
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_wa", 32'(out_wa), 32'd5);
            check("t3_hold_mwd", 32'(out_mwd_sel), 32'd1);
            check("t3_hold_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_next_wa", 32'(out_wa), 32'd6);
        check("t3_next_alu", 32'(out_alu_sel), 32'd3);

        // load-use: lw rt=5 then add rs=5
        cyc();
        set_in(1'b1, I_LW, 5'd0, 5'd5, 5'd0);
        cyc();
        set_in(1'b1, I_ADD, 5'd5, 5'd1, 5'd7);
        @(negedge clk);
        check("t4_hazard_ready", 32'(in_ready), 32'd0);
        cyc();
        @(negedge clk);
        check("t4_bubble", 32'(out_valid), 32'd0);
        check("t4_ready_after_bubble", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_dep_valid", 32'(out_valid), 32'd1);
        check("t4_dep_wa", 32'(out_wa), 32'd7);

        // divu occupies the divider for DIV_LAT-1 cycles
        cyc();
        set_in(1'b1, I_DIVU, 5'd1, 5'd2, 5'd0);
        cyc();
        set_in(1'b1, I_ADDU, 5'd1, 5'd2, 5'd3);
        for (int i = 1; i < DIV_LAT; i++) begin
            @(negedge clk);
            check("t5_busy", 32'(busy), 32'd1);
            check("t5_stall", 32'(in_ready), 32'd0);
            cyc();
        end
        @(negedge clk);
        check("t5_busy_done", 32'(busy), 32'd0);
        check("t5_ready_again", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;

        // flush aborts DIV_WAIT, then a reserved opcode
        cyc();
        set_in(1'b1, I_DIVU, 5'd1, 5'd2, 5'd0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd1);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        set_in(1'b1, I_BAD, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("t6_busy_cleared", 32'(busy), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_illegal_valid", 32'(out_valid), 32'd1);
        check("t6_illegal", 32'(out_illegal), 32'd1);
        check("t6_illegal_reg_we", 32'(out_reg_we), 32'd0);
        check("t6_illegal_dmem_we", 32'(out_dmem_we), 32'd0);

        // no load-use detection: lw then dependent add issue back to back
        cyc();
        set_nl(1'b1, I_LW, 5'd0, 5'd5, 5'd0);
        cyc();
        set_nl(1'b1, I_ADD, 5'd5, 5'd1, 5'd7);
        @(negedge clk);
        check("nl_ready", 32'(n_in_ready), 32'd1);
        check("nl_lw_valid", 32'(n_out_valid), 32'd1);
        cyc();
        n_in_valid = 1'b0;
        @(negedge clk);
        check("nl_back_to_back", 32'(n_out_valid), 32'd1);
        check("nl_add_wa", 32'(n_out_wa_fix()), 32'd7);

        // random traffic
        repeat (3000) begin
            cyc();
            k = instr_e'($urandom_range(0, 13));
            set_in($urandom_range(0, 9) < 7, k, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (k == I_BAD) {in_opcode, in_func} = enc_reserved($urandom_range(0, 4));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
        end
        cyc();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (DIV_LAT + 4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [4:0] n_out_wa_fix();
        return n_wa;
    endfunction

endmodule
